// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared Mux4 path: one-hot grant, mux select, hold timeout.
// Define ARB_LOCK_EN to add the lock port that exempts the current owner from the timeout.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [1:0]       last;

  logic [1:0] pick;
  logic [1:0] scanIdx;
  logic       hit;
  logic       lockOn;
  logic       dropExit;
  logic       holdExit;

`ifdef ARB_LOCK_EN
  assign lockOn = lock;
`else
  assign lockOn = 1'b0;
`endif

  // Scan starts just after the previous owner so it goes last.
  always_comb begin
    pick    = last;
    scanIdx = last;
    hit     = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      scanIdx = last + 2'(k);
      if (!hit && req[scanIdx]) begin
        hit  = 1'b1;
        pick = scanIdx;
      end
    end
  end

  assign dropExit = !req[sel];
  assign holdExit = (count == HOLD_LAST) && !lockOn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      count   <= '0;
      last    <= 2'd3;
    end else begin
      unique case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (hit) begin
            gnt   <= 4'b0001 << pick;
            sel   <= pick;
            last  <= pick;
            busy  <= 1'b1;
            count <= '0;
            state <= GRANT;
          end else begin
            gnt <= 4'b0000;
          end
        end
        GRANT: begin
          if (done || dropExit || holdExit) begin
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            state   <= IDLE;
            // Done or a dropped request takes precedence over revocation.
            timeout <= holdExit && !done && !dropExit;
          end else if (count != HOLD_LAST) begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, rotation, timeout, async reset.
// Lock scenario runs only when ARB_LOCK_EN is defined.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif

  int tests;
  int fails;

  mux4_rr_arbiter #(.MAX_HOLD(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
`ifdef ARB_LOCK_EN
    .lock   (lock),
`endif
    .gnt    (gnt),
    .sel    (sel),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] order [5];
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
`ifdef ARB_LOCK_EN
    lock  = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;

    chk("rst_gnt", 8'(gnt), 8'h0);
    chk("rst_sel", 8'(sel), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_to", 8'(timeout), 8'h0);

    // Single request, done ends ownership.
    req = 4'b0001;
    step();
    chk("r0_gnt", 8'(gnt), 8'h1);
    chk("r0_sel", 8'(sel), 8'h0);
    chk("r0_busy", 8'(busy), 8'h1);
    done = 1'b1;
    req  = 4'b0000;
    step();
    done = 1'b0;
    chk("r0_rel", 8'(gnt), 8'h0);
    chk("r0_relb", 8'(busy), 8'h0);
    chk("r0_relt", 8'(timeout), 8'h0);

    // Full contention rotates 0,1,2,3,0 with one idle gap.
    doReset();
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", 8'(gnt), 8'(order[k]));
      chk("rr_sel", 8'(sel), 8'(k % 4));
      done = 1'b1;
      step();
      done = 1'b0;
      chk("rr_gap", 8'(gnt), 8'h0);
      step();
    end
    req = 4'b0000;
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    chk("rr_idle", 8'(gnt), 8'h0);

    // Sole requester: 16 grant cycles, timeout pulse, gap, regrant.
    req = 4'b0100;
    step();
    chk("to_g0", 8'(gnt), 8'h4);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("to_hold", 8'({timeout, gnt}), 8'h04);
    end
    step();
    chk("to_gap", 8'(gnt), 8'h0);
    chk("to_pulse", 8'(timeout), 8'h1);
    chk("to_sel", 8'(sel), 8'h2);
    chk("to_busy", 8'(busy), 8'h0);
    step();
    chk("to_regnt", 8'(gnt), 8'h4);
    chk("to_clr", 8'(timeout), 8'h0);

    // done on the final hold cycle wins over timeout.
    for (int i = 0; i < 15; i++) step();
    chk("dt_pre", 8'(gnt), 8'h4);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("dt_gnt", 8'(gnt), 8'h0);
    chk("dt_to", 8'(timeout), 8'h0);
    req = 4'b0000;
    step();

    // Asynchronous reset mid-grant.
    doReset();
    req = 4'b0010;
    step();
    chk("ar_pre", 8'(gnt), 8'h2);
    rst = 1'b1;
    #1;
    chk("ar_gnt", 8'(gnt), 8'h0);
    chk("ar_sel", 8'(sel), 8'h0);
    chk("ar_busy", 8'(busy), 8'h0);
    rst = 1'b0;
    req = 4'b0011;
    step();
    chk("ar_w0", 8'(gnt), 8'h1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("ar_gap", 8'(gnt), 8'h0);
    step();
    chk("ar_w1", 8'(gnt), 8'h2);
    chk("ar_s1", 8'(sel), 8'h1);
    req = 4'b0000;
    step();
    step();

`ifdef ARB_LOCK_EN
    // Locked owner keeps the grant past MAX_HOLD.
    lock = 1'b1;
    req  = 4'b1000;
    step();
    for (int i = 0; i < 40; i++) begin
      chk("lk_hold", 8'({timeout, gnt}), 8'h08);
      step();
    end
    done = 1'b1;
    step();
    done = 1'b0;
    lock = 1'b0;
    chk("lk_rel", 8'(gnt), 8'h0);
    chk("lk_to", 8'(timeout), 8'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
